// File: rtl/registro_pkg.sv
// Shared definitions for the registro_fila operand/opcode input register:
// capture state encodings, default widths and a constant clog2 helper.
package registro_pkg;

  localparam int unsigned DATA_W_DEF        = 4;
  localparam int unsigned OPER_W_DEF        = 4;
  localparam int unsigned STABLE_CYCLES_DEF = 2;
  localparam int unsigned DEPTH_DEF         = 4;

  typedef logic [1:0] estado_t;

  localparam estado_t OCIOSO  = 2'd0;
  localparam estado_t AMOSTRA = 2'd1;
  localparam estado_t TRAVADO = 2'd2;

  // Ceiling log2 usable in parameter/port width expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fila_registro.sv
// Generic synchronous FIFO with registered occupancy and combinational head read.
// Works for any DEPTH >= 2; pointers wrap explicitly at DEPTH-1.
module fila_registro
  import registro_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic                         cheio,
  output logic                         vazio,
  output logic [clog2(DEPTH+1)-1:0]    ocupacao
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned OCC_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign vazio   = (ocupacao == '0);
  assign cheio   = (ocupacao == OCC_W'(DEPTH));
  assign do_pop  = pop && !vazio;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!cheio || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ocupacao <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   ocupacao <= ocupacao + OCC_W'(1);
        2'b01:   ocupacao <= ocupacao - OCC_W'(1);
        default: ocupacao <= ocupacao;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/registro_fila.sv
// Operand/opcode input register: qualifies a word as stable over STABLE_CYCLES
// samples while Hab is high, buffers accepted words and presents the FIFO head.
module registro_fila
  import registro_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned OPER_W        = OPER_W_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned DEPTH         = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Hab,
  input  logic [DATA_W+OPER_W-1:0]     In,
  input  logic                         pronto,
  output logic [DATA_W-1:0]            saida_dados,
  output logic [OPER_W-1:0]            saida_oper,
  output logic                         saida_valida,
  output logic                         Fim,
  output logic [clog2(DEPTH+1)-1:0]    ocupacao
);

  localparam int unsigned W  = DATA_W + OPER_W;
  localparam int unsigned CW = clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CONT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CONT_LIM = CW'(STABLE_CYCLES - 1);

  estado_t        estado, estado_n;
  logic [CW-1:0]  cont, cont_n;
  logic [W-1:0]   ultimo, ultimo_n;
  logic           fim_n;
  logic           push;
  logic           pop;
  logic           espaco;
  logic           cheio;
  logic           vazio;
  logic [W-1:0]   head;

  assign pop    = !vazio && pronto;
  assign espaco = !cheio || pop;

  always_comb begin
    estado_n = estado;
    cont_n   = cont;
    ultimo_n = ultimo;
    fim_n    = Fim;
    push     = 1'b0;
    case (estado)
      OCIOSO: begin
        fim_n = 1'b0;
        if (Hab) begin
          ultimo_n = In;
          cont_n   = CW'(1);
          estado_n = AMOSTRA;
        end
      end
      AMOSTRA: begin
        if (!Hab) begin
          cont_n   = '0;
          estado_n = OCIOSO;
        end else if (In != ultimo) begin
          ultimo_n = In;
          cont_n   = CW'(1);
        end else if (cont >= CONT_LIM) begin
          // Qualified word: without space the counter stays saturated and the
          // push is retried every cycle until the FIFO drains.
          cont_n = CONT_MAX;
          if (espaco) begin
            push     = 1'b1;
            fim_n    = 1'b1;
            estado_n = TRAVADO;
          end
        end else begin
          cont_n = cont + CW'(1);
        end
      end
      TRAVADO: begin
        fim_n = 1'b1;
        if (!Hab) begin
          fim_n    = 1'b0;
          cont_n   = '0;
          estado_n = OCIOSO;
        end
      end
      default: begin
        estado_n = OCIOSO;
        cont_n   = '0;
        fim_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
      cont   <= '0;
      ultimo <= '0;
      Fim    <= 1'b0;
    end else begin
      estado <= estado_n;
      cont   <= cont_n;
      ultimo <= ultimo_n;
      Fim    <= fim_n;
    end
  end

  fila_registro #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fila (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      (ultimo),
    .head     (head),
    .cheio    (cheio),
    .vazio    (vazio),
    .ocupacao (ocupacao)
  );

  assign saida_valida = !vazio;
  assign saida_dados  = vazio ? '0 : head[DATA_W-1:0];
  assign saida_oper   = vazio ? '0 : head[W-1:DATA_W];

endmodule

// File: tb/tb_registro_fila.sv
// Directed self-checking bench for registro_fila at default parameters.
module tb_registro_fila;

  logic       clk;
  logic       rst;
  logic       Hab;
  logic [7:0] In;
  logic       pronto;
  logic [3:0] saida_dados;
  logic [3:0] saida_oper;
  logic       saida_valida;
  logic       Fim;
  logic [2:0] ocupacao;

  int checks   = 0;
  int failures = 0;

  registro_fila #(
    .DATA_W        (4),
    .OPER_W        (4),
    .STABLE_CYCLES (2),
    .DEPTH         (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Hab          (Hab),
    .In           (In),
    .pronto       (pronto),
    .saida_dados  (saida_dados),
    .saida_oper   (saida_oper),
    .saida_valida (saida_valida),
    .Fim          (Fim),
    .ocupacao     (ocupacao)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] word, input logic v,
                         input logic f, input logic [2:0] occ);
    chk({tag, "_head"}, {saida_oper, saida_dados}, word);
    chk({tag, "_valida"}, {7'd0, saida_valida}, {7'd0, v});
    chk({tag, "_fim"}, {7'd0, Fim}, {7'd0, f});
    chk({tag, "_ocup"}, {5'd0, ocupacao}, {5'd0, occ});
  endtask

  task automatic push_word(input logic [7:0] w);
    Hab = 1'b1; In = w;
    tick();
    tick();
    Hab = 1'b0;
    tick();
  endtask

  logic [7:0] seq [6];

  initial begin
    rst = 1'b1; Hab = 1'b0; In = 8'h00; pronto = 1'b0;
    #3;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 3'd0);
    @(negedge clk); rst = 1'b0;

    // Minimum-latency accept of A3
    Hab = 1'b1; In = 8'hA3;
    tick();
    chk_all("a3_e0", 8'h00, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("a3_e1", 8'hA3, 1'b1, 1'b1, 3'd1);
    Hab = 1'b0;
    tick();
    chk("a3_fim_drop", {7'd0, Fim}, 8'h00);
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    chk_all("a3_pop", 8'h00, 1'b0, 1'b0, 3'd0);

    // Changing input restarts qualification: only 13 stored
    Hab = 1'b1; In = 8'h12;
    tick();
    In = 8'h13;
    tick();
    chk_all("r13_restart", 8'h00, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("r13_acc", 8'h13, 1'b1, 1'b1, 3'd1);
    Hab = 1'b0;
    tick();
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    chk_all("r13_pop", 8'h00, 1'b0, 1'b0, 3'd0);

    // Fill, then stall a fifth word until a pop frees a slot on the same edge
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    chk_all("full", 8'h11, 1'b1, 1'b0, 3'd4);
    Hab = 1'b1; In = 8'h55;
    tick();
    tick();
    chk_all("stall1", 8'h11, 1'b1, 1'b0, 3'd4);
    tick();
    chk_all("stall2", 8'h11, 1'b1, 1'b0, 3'd4);
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    chk_all("pushpop", 8'h22, 1'b1, 1'b1, 3'd4);

    // Locked: changing In with Hab held must not push
    In = 8'h66;
    tick();
    In = 8'h77;
    tick();
    chk_all("locked", 8'h22, 1'b1, 1'b1, 3'd4);
    Hab = 1'b0;
    tick();
    chk("rearm_fim", {7'd0, Fim}, 8'h00);
    seq[0] = 8'h22; seq[1] = 8'h33; seq[2] = 8'h44; seq[3] = 8'h55;
    pronto = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), {saida_oper, saida_dados}, seq[i]);
      tick();
    end
    pronto = 1'b0;
    chk_all("drained", 8'h00, 1'b0, 1'b0, 3'd0);
    Hab = 1'b1; In = 8'h9C;
    tick();
    tick();
    chk_all("rearm_acc", 8'h9C, 1'b1, 1'b1, 3'd1);
    Hab = 1'b0;
    tick();
    pronto = 1'b1;
    tick();
    pronto = 1'b0;

    // Six words through with continuous pop: order and pointer wrap
    seq[0] = 8'h01; seq[1] = 8'hF2; seq[2] = 8'h3D; seq[3] = 8'hC4;
    seq[4] = 8'h5B; seq[5] = 8'hA6;
    pronto = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Hab = 1'b1; In = seq[i];
      tick();
      tick();
      chk($sformatf("stream%0d_head", i), {saida_oper, saida_dados}, seq[i]);
      chk($sformatf("stream%0d_ocup", i), {5'd0, ocupacao}, 8'd1);
      Hab = 1'b0;
      tick();
      chk($sformatf("stream%0d_empty", i), {5'd0, ocupacao}, 8'd0);
    end
    pronto = 1'b0;
    chk_all("stream_end", 8'h00, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset mid-AMOSTRA with three entries stored
    push_word(8'h81);
    push_word(8'h82);
    push_word(8'h83);
    chk_all("pre_rst", 8'h81, 1'b1, 1'b0, 3'd3);
    Hab = 1'b1; In = 8'hEE;
    tick();
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 1'b0, 3'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk_all("post_rst_e0", 8'h00, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("post_rst_e1", 8'hEE, 1'b1, 1'b1, 3'd1);
    Hab = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
